// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// Shared definitions for the ysyx_041461 pipeline control unit (CD).
// The enum holds the flush FSM state encodings.
package ysyx_041461_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ysyx_041461_CD_RUN     = 2'd0,
        ysyx_041461_CD_WAIT_IF = 2'd1,
        ysyx_041461_CD_FLUSH   = 2'd2
    } cd_state_e;

    localparam int unsigned REG_ADDR_W = 5;

endpackage

// File: rtl/ysyx_041461_pipe_ctrl_if.sv
// Bundle between the pipeline control unit and the pipeline stages.
// The master modport is the control unit, and the slave modport is the pipeline side.
interface ysyx_041461_pipe_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    import ysyx_041461_pipe_ctrl_pkg::*;

    logic                   id_valid;
    logic [REG_ADDR_W-1:0]  id_rs1;
    logic [REG_ADDR_W-1:0]  id_rs2;
    logic                   id_use_rs1;
    logic                   id_use_rs2;
    logic                   exe_valid;
    logic [REG_ADDR_W-1:0]  exe_rd;
    logic                   exe_is_load;
    logic                   exe_busy;
    logic                   exe_redirect;
    logic                   mem_req;
    logic                   mem_ready;
    logic                   if_req;
    logic                   if_ready;
    logic                   wb_trap;

    logic                   pc_enable;
    logic                   pc_trap_sel;
    logic                   IFreg_enable;
    logic                   IDreg_enable;
    logic                   EXEreg_enable;
    logic                   MEMreg_enable;
    logic                   WBreg_enable;
    logic                   IDreg_valid_fromCD;
    logic                   EXEreg_valid_fromCD;
    logic                   MEMreg_valid_fromCD;
    logic                   WBreg_valid_fromCD;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  exe_valid, exe_rd, exe_is_load, exe_busy, exe_redirect,
        input  mem_req, mem_ready, if_req, if_ready, wb_trap,
        output pc_enable, pc_trap_sel,
        output IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable,
        output IDreg_valid_fromCD, EXEreg_valid_fromCD, MEMreg_valid_fromCD, WBreg_valid_fromCD,
        output stall_cycles
    );

    modport slave (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output exe_valid, exe_rd, exe_is_load, exe_busy, exe_redirect,
        output mem_req, mem_ready, if_req, if_ready, wb_trap,
        input  pc_enable, pc_trap_sel,
        input  IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable,
        input  IDreg_valid_fromCD, EXEreg_valid_fromCD, MEMreg_valid_fromCD, WBreg_valid_fromCD,
        input  stall_cycles
    );

endinterface

// File: rtl/ysyx_041461_load_use_cmp.sv
// Load-use hazard detector. It flags an ID instruction that reads the
// non-zero destination register of a load currently in EXE.
module ysyx_041461_load_use_cmp
    import ysyx_041461_pipe_ctrl_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  exe_valid,
    input  logic [REG_ADDR_W-1:0] exe_rd,
    input  logic                  exe_is_load,
    output logic                  lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == exe_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == exe_rd);

    // x0 never carries a real dependency, so a load into x0 does not stall.
    assign lu = exe_valid && exe_is_load && (exe_rd != '0) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline control unit. It contains the priority stall/flush mux, the trap flush FSM
// and a saturating count of the cycles in which the PC is held.
module ysyx_041461_pipe_ctrl
    import ysyx_041461_pipe_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_041461_pipe_ctrl_if.master  cd
);

    cd_state_e              state;
    cd_state_e              state_nxt;
    logic                   lu;
    logic                   memstall;
    logic                   ifpend;
    logic                   pc_en;
    logic                   trap_sel;
    logic [4:0]             stage_en;
    logic [3:0]             stage_vld;
    logic [STALL_CNT_W-1:0] stall_cnt;

    ysyx_041461_load_use_cmp u_lu_cmp (
        .id_valid    (cd.id_valid),
        .id_rs1      (cd.id_rs1),
        .id_rs2      (cd.id_rs2),
        .id_use_rs1  (cd.id_use_rs1),
        .id_use_rs2  (cd.id_use_rs2),
        .exe_valid   (cd.exe_valid),
        .exe_rd      (cd.exe_rd),
        .exe_is_load (cd.exe_is_load),
        .lu          (lu)
    );

    assign memstall = cd.mem_req && !cd.mem_ready;
    assign ifpend   = cd.if_req && !cd.if_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ysyx_041461_CD_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // stage_en is {IF,ID,EXE,MEM,WB} and stage_vld is {ID,EXE,MEM,WB}. Reset forces the idle values.
    always_comb begin
        pc_en     = 1'b1;
        trap_sel  = 1'b0;
        stage_en  = 5'b11111;
        stage_vld = 4'b1111;
        state_nxt = state;
        if (!rst) begin
            unique case (state)
                ysyx_041461_CD_RUN: begin
                    if (cd.wb_trap) begin
                        pc_en     = 1'b0;
                        stage_en  = 5'b00000;
                        state_nxt = ifpend ? ysyx_041461_CD_WAIT_IF : ysyx_041461_CD_FLUSH;
                    end else if (memstall) begin
                        pc_en    = 1'b0;
                        stage_en = 5'b00000;
                    end else if (cd.exe_busy || (cd.exe_redirect && ifpend)) begin
                        // Holding EXE keeps a pending redirect alive until fetch settles.
                        pc_en        = 1'b0;
                        stage_en     = 5'b00011;
                        stage_vld[1] = 1'b0;
                    end else if (cd.exe_redirect) begin
                        stage_vld[3] = 1'b0;
                        stage_vld[2] = 1'b0;
                    end else if (lu) begin
                        pc_en        = 1'b0;
                        stage_en     = 5'b00111;
                        stage_vld[2] = 1'b0;
                    end else if (ifpend) begin
                        pc_en        = 1'b0;
                        stage_en     = 5'b01111;
                        stage_vld[3] = 1'b0;
                    end
                end
                ysyx_041461_CD_WAIT_IF: begin
                    pc_en    = 1'b0;
                    stage_en = 5'b00000;
                    if (cd.if_ready) begin
                        state_nxt = ysyx_041461_CD_FLUSH;
                    end
                end
                ysyx_041461_CD_FLUSH: begin
                    trap_sel  = 1'b1;
                    stage_vld = 4'b0000;
                    state_nxt = ysyx_041461_CD_RUN;
                end
                default: begin
                    state_nxt = ysyx_041461_CD_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign cd.pc_enable           = pc_en;
    assign cd.pc_trap_sel         = trap_sel;
    assign cd.IFreg_enable        = stage_en[4];
    assign cd.IDreg_enable        = stage_en[3];
    assign cd.EXEreg_enable       = stage_en[2];
    assign cd.MEMreg_enable       = stage_en[1];
    assign cd.WBreg_enable        = stage_en[0];
    assign cd.IDreg_valid_fromCD  = stage_vld[3];
    assign cd.EXEreg_valid_fromCD = stage_vld[2];
    assign cd.MEMreg_valid_fromCD = stage_vld[1];
    assign cd.WBreg_valid_fromCD  = stage_vld[0];
    assign cd.stall_cycles        = stall_cnt;

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Directed bench for the pipeline control unit. The output word is
// {pc_en, trap_sel, IF,ID,EXE,MEM,WB enables, ID,EXE,MEM,WB valid_fromCD}.
module tb_ysyx_041461_pipe_ctrl;

    localparam int STALL_CNT_W = 32;

    localparam logic [10:0] IDLE   = 11'b1_0_11111_1111;
    localparam logic [10:0] FREEZE = 11'b0_0_00000_1111;
    localparam logic [10:0] BUSY   = 11'b0_0_00011_1101;
    localparam logic [10:0] REDIR  = 11'b1_0_11111_0011;
    localparam logic [10:0] LUSE   = 11'b0_0_00111_1011;
    localparam logic [10:0] IFP    = 11'b0_0_01111_0111;
    localparam logic [10:0] FLUSH  = 11'b1_1_11111_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_041461_pipe_ctrl_if #(.STALL_CNT_W(STALL_CNT_W)) cd ();

    ysyx_041461_pipe_ctrl #(.STALL_CNT_W(STALL_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .cd  (cd.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] outs;
    assign outs = {cd.pc_enable, cd.pc_trap_sel,
                   cd.IFreg_enable, cd.IDreg_enable, cd.EXEreg_enable, cd.MEMreg_enable, cd.WBreg_enable,
                   cd.IDreg_valid_fromCD, cd.EXEreg_valid_fromCD, cd.MEMreg_valid_fromCD, cd.WBreg_valid_fromCD};

    task automatic clearInputs();
        cd.id_valid     = 1'b0;
        cd.id_rs1       = '0;
        cd.id_rs2       = '0;
        cd.id_use_rs1   = 1'b0;
        cd.id_use_rs2   = 1'b0;
        cd.exe_valid    = 1'b0;
        cd.exe_rd       = '0;
        cd.exe_is_load  = 1'b0;
        cd.exe_busy     = 1'b0;
        cd.exe_redirect = 1'b0;
        cd.mem_req      = 1'b0;
        cd.mem_ready    = 1'b0;
        cd.if_req       = 1'b0;
        cd.if_ready     = 1'b0;
        cd.wb_trap      = 1'b0;
    endtask

    // Advance one full clock and return at the following falling edge.
    task automatic applyStimulus();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [10:0] expected);
        #1;
        checks++;
        assert (outs === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, outs, expected);
        end
    endtask

    task automatic checkCount(input string tag, input logic [STALL_CNT_W-1:0] expected);
        checks++;
        assert (cd.stall_cycles === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, cd.stall_cycles, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clearInputs();
        applyStimulus();

        cd.mem_req = 1'b1;
        checkOutput("reset_idle", IDLE);
        checkCount("reset_cnt", 0);
        applyStimulus();
        clearInputs();
        rst = 1'b0;

        cd.exe_valid   = 1'b1;
        cd.exe_is_load = 1'b1;
        cd.exe_rd      = 5'd5;
        cd.id_valid    = 1'b1;
        cd.id_use_rs1  = 1'b1;
        cd.id_rs1      = 5'd3;
        cd.id_use_rs2  = 1'b1;
        cd.id_rs2      = 5'd5;
        checkOutput("load_use_x5", LUSE);
        applyStimulus();
        clearInputs();
        checkOutput("after_lu", IDLE);
        checkCount("cnt_after_lu", 1);
        applyStimulus();

        cd.exe_valid   = 1'b1;
        cd.exe_is_load = 1'b1;
        cd.exe_rd      = 5'd7;
        cd.id_valid    = 1'b1;
        cd.id_rs1      = 5'd7;
        cd.id_use_rs1  = 1'b0;
        checkOutput("rs1_unused", IDLE);
        applyStimulus();

        cd.exe_rd     = 5'd0;
        cd.id_rs1     = 5'd0;
        cd.id_rs2     = 5'd0;
        cd.id_use_rs1 = 1'b1;
        cd.id_use_rs2 = 1'b1;
        checkOutput("load_x0", IDLE);
        checkCount("cnt_x0", 1);
        applyStimulus();
        clearInputs();

        cd.mem_req      = 1'b1;
        cd.exe_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("memstall", FREEZE);
            applyStimulus();
        end
        cd.mem_ready = 1'b1;
        checkOutput("redirect", REDIR);
        checkCount("cnt_memstall", 4);
        applyStimulus();
        clearInputs();

        cd.exe_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("exe_busy", BUSY);
            applyStimulus();
        end
        cd.exe_busy = 1'b0;
        checkOutput("after_busy", IDLE);
        checkCount("cnt_busy", 8);
        applyStimulus();

        cd.exe_redirect = 1'b1;
        cd.if_req       = 1'b1;
        checkOutput("redirect_ifpend", BUSY);
        applyStimulus();
        cd.exe_redirect = 1'b0;
        checkOutput("ifpend", IFP);
        applyStimulus();
        clearInputs();

        cd.wb_trap = 1'b1;
        cd.if_req  = 1'b1;
        checkOutput("trap_freeze", FREEZE);
        checkCount("cnt_before_trap", 10);
        applyStimulus();
        checkOutput("wait_if_1", FREEZE);
        applyStimulus();
        cd.if_ready = 1'b1;
        checkOutput("wait_if_2", FREEZE);
        applyStimulus();
        checkOutput("flush", FLUSH);
        checkCount("cnt_trap", 13);
        applyStimulus();
        clearInputs();
        checkOutput("after_flush", IDLE);
        applyStimulus();

        cd.wb_trap = 1'b1;
        checkOutput("trap_direct", FREEZE);
        applyStimulus();
        checkOutput("flush_direct", FLUSH);
        checkCount("cnt_trap_direct", 14);
        applyStimulus();
        clearInputs();

        cd.wb_trap = 1'b1;
        cd.if_req  = 1'b1;
        applyStimulus();
        cd.wb_trap = 1'b0;
        checkOutput("wait_before_rst", FREEZE);
        rst = 1'b1;
        checkOutput("rst_in_wait", IDLE);
        checkCount("rst_cnt", 0);
        applyStimulus();
        clearInputs();
        rst = 1'b0;
        cd.if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("no_flush_after_rst", IDLE);
            applyStimulus();
        end
        checkCount("cnt_after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
